// File: rtl/sp_unpacker_buffered.sv
// Service-protocol unpacker: parses HEAD1/HEAD2/DATA/CRC/NUM, buffers payload until it is committed.
// Latency: status pulses one cycle after the deciding word; committed words visible with pkt_ok.
// Backpressure: out_valid/out_ready on the read side; the write side never stalls (NO_SPACE rejects instead).
module sp_unpacker_buffered #(
    parameter int DATA_W         = 16,
    parameter int BUF_DEPTH      = 256,
    parameter int MAX_WORDS      = 255,
    parameter int NUM_CMDS       = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_frame,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [DATA_W-1:0]            own_addr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_last,
    output logic                         pkt_start,
    output logic                         pkt_ok,
    output logic                         pkt_err,
    output logic                         pkt_skip,
    output logic [2:0]                   err_code,
    output logic [DATA_W-1:0]            hdr_addr,
    output logic [7:0]                   hdr_cmd,
    output logic [DATA_W-9:0]            hdr_size,
    output logic [DATA_W-1:0]            hdr_num,
    output logic [$clog2(BUF_DEPTH):0]   buf_level
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = DATA_W - 8;
    // Compare width wide enough for both the size field and the free-space value.
    localparam int CW = ((SW > PW) ? SW : PW) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] E_CRC      = 3'd1;
    localparam logic [2:0] E_BAD_CMD  = 3'd2;
    localparam logic [2:0] E_NO_SPACE = 3'd3;
    localparam logic [2:0] E_TOO_LONG = 3'd4;
    localparam logic [2:0] E_TIMEOUT  = 3'd5;
    localparam logic [2:0] E_ABORT    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE, S_HEAD1, S_HEAD2, S_DATA, S_CRC, S_NUM, S_DRAIN
    } state_t;

    // Payload store: data plus the last-of-packet flag.
    logic [DATA_W:0]     r_mem [BUF_DEPTH];

    state_t              r_state, w_state_nxt;
    logic [PW-1:0]       r_wr_ptr, w_wr_nxt;
    logic [PW-1:0]       r_rd_ptr;
    logic [PW-1:0]       r_commit_ptr, w_commit_nxt;
    logic [DATA_W-1:0]   r_crc, w_crc_nxt;
    logic [TW-1:0]       r_timer, w_timer_nxt;
    logic [SW-1:0]       r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]   r_addr, w_addr_nxt;
    logic [SW-1:0]       r_size, w_size_nxt;
    logic [7:0]          r_cmd, w_cmd_nxt;
    logic                r_skip, w_skip_nxt;
    logic                r_bad, w_bad_nxt;
    logic                r_pkt_start, w_pkt_start_nxt;
    logic                r_pkt_ok, w_pkt_ok_nxt;
    logic                r_pkt_err, w_pkt_err_nxt;
    logic                r_pkt_skip, w_pkt_skip_nxt;
    logic [2:0]          r_err_code, w_err_code_nxt;
    logic [DATA_W-1:0]   r_hdr_addr, w_hdr_addr_nxt;
    logic [7:0]          r_hdr_cmd, w_hdr_cmd_nxt;
    logic [SW-1:0]       r_hdr_size, w_hdr_size_nxt;
    logic [DATA_W-1:0]   r_hdr_num, w_hdr_num_nxt;

    logic                w_wr_en;
    logic                w_wr_last;
    logic                w_in_pkt;
    logic                w_timeout;
    logic [SW-1:0]       w_in_size;
    logic [7:0]          w_in_cmd;
    logic [PW-1:0]       w_level;
    logic [CW-1:0]       w_space;
    logic                w_foreign;
    logic                w_out_valid;
    logic                w_pop;
    logic [DATA_W:0]     w_rd_word;

    assign w_in_size   = in_data[DATA_W-1:8];
    assign w_in_cmd    = in_data[7:0];
    assign w_level     = r_wr_ptr - r_rd_ptr;
    assign w_space     = CW'(BUF_DEPTH) - CW'(w_level);
    assign w_foreign   = (r_addr != own_addr) && (r_addr != {DATA_W{1'b1}});
    assign w_in_pkt    = (r_state == S_HEAD2) || (r_state == S_DATA) ||
                         (r_state == S_CRC)   || (r_state == S_NUM);
    assign w_timeout   = w_in_pkt && !in_valid && (r_timer == TW'(TIMEOUT_CYCLES - 1));
    assign w_out_valid = (r_rd_ptr != r_commit_ptr);
    assign w_pop       = w_out_valid && out_ready;
    assign w_rd_word   = r_mem[r_rd_ptr[AW-1:0]];

    // Next-state, datapath and status-pulse decode for the packet parser.
    always_comb begin
        w_state_nxt      = r_state;
        w_wr_nxt         = r_wr_ptr;
        w_commit_nxt     = r_commit_ptr;
        w_crc_nxt        = r_crc;
        w_timer_nxt      = '0;
        w_cnt_nxt        = r_cnt;
        w_addr_nxt       = r_addr;
        w_size_nxt       = r_size;
        w_cmd_nxt        = r_cmd;
        w_skip_nxt       = r_skip;
        w_bad_nxt        = r_bad;
        w_pkt_start_nxt  = 1'b0;
        w_pkt_ok_nxt     = 1'b0;
        w_pkt_err_nxt    = 1'b0;
        w_pkt_skip_nxt   = 1'b0;
        w_err_code_nxt   = r_err_code;
        w_hdr_addr_nxt   = r_hdr_addr;
        w_hdr_cmd_nxt    = r_hdr_cmd;
        w_hdr_size_nxt   = r_hdr_size;
        w_hdr_num_nxt    = r_hdr_num;
        w_wr_en          = 1'b0;
        w_wr_last        = 1'b0;

        if (w_in_pkt && !in_valid) begin
            w_timer_nxt = r_timer + TW'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (in_frame) begin
                    w_state_nxt = S_HEAD1;
                end
            end
            S_HEAD1: begin
                if (!in_frame) begin
                    w_state_nxt = S_IDLE;
                end else if (in_valid) begin
                    w_addr_nxt  = in_data;
                    w_crc_nxt   = in_data;
                    w_skip_nxt  = 1'b0;
                    w_bad_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_HEAD2;
                end
            end
            S_DRAIN: begin
                if (!in_frame) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                if (!in_frame) begin
                    // Frame dropped mid-packet: discard speculative words.
                    w_wr_nxt       = r_commit_ptr;
                    w_pkt_err_nxt  = 1'b1;
                    w_err_code_nxt = E_ABORT;
                    w_timer_nxt    = '0;
                    w_state_nxt    = S_IDLE;
                end else if (w_timeout) begin
                    w_wr_nxt       = r_commit_ptr;
                    w_pkt_err_nxt  = 1'b1;
                    w_err_code_nxt = E_TIMEOUT;
                    w_timer_nxt    = '0;
                    w_state_nxt    = S_HEAD1;
                end else if (in_valid) begin
                    w_crc_nxt = r_crc + in_data;
                    case (r_state)
                        S_HEAD2: begin
                            w_size_nxt = w_in_size;
                            w_cmd_nxt  = w_in_cmd;
                            w_cnt_nxt  = '0;
                            if ({1'b0, w_in_cmd} >= 9'(NUM_CMDS)) begin
                                w_pkt_err_nxt  = 1'b1;
                                w_err_code_nxt = E_BAD_CMD;
                                w_state_nxt    = S_DRAIN;
                            end else if (CW'(w_in_size) > CW'(MAX_WORDS)) begin
                                w_pkt_err_nxt  = 1'b1;
                                w_err_code_nxt = E_TOO_LONG;
                                w_state_nxt    = S_DRAIN;
                            end else if (w_foreign) begin
                                // Someone else's packet: walk through it without storing.
                                w_skip_nxt  = 1'b1;
                                w_state_nxt = (w_in_size == '0) ? S_CRC : S_DATA;
                            end else if (CW'(w_in_size) > w_space) begin
                                w_pkt_err_nxt  = 1'b1;
                                w_err_code_nxt = E_NO_SPACE;
                                w_state_nxt    = S_DRAIN;
                            end else begin
                                w_pkt_start_nxt = 1'b1;
                                w_state_nxt     = (w_in_size == '0) ? S_CRC : S_DATA;
                            end
                        end
                        S_DATA: begin
                            if (!r_skip) begin
                                w_wr_en   = 1'b1;
                                w_wr_last = (r_cnt == (r_size - SW'(1)));
                                w_wr_nxt  = r_wr_ptr + PW'(1);
                            end
                            w_cnt_nxt = r_cnt + SW'(1);
                            if (r_cnt == (r_size - SW'(1))) begin
                                w_state_nxt = S_CRC;
                            end
                        end
                        S_CRC: begin
                            // The checksum word itself is compared, not accumulated.
                            w_crc_nxt = r_crc;
                            if ((in_data != r_crc) && !r_skip) begin
                                w_pkt_err_nxt  = 1'b1;
                                w_err_code_nxt = E_CRC;
                                w_wr_nxt       = r_commit_ptr;
                                w_bad_nxt      = 1'b1;
                            end
                            w_state_nxt = S_NUM;
                        end
                        S_NUM: begin
                            w_crc_nxt = r_crc;
                            if (r_skip) begin
                                w_pkt_skip_nxt = 1'b1;
                            end else if (!r_bad) begin
                                w_commit_nxt   = r_wr_ptr;
                                w_hdr_addr_nxt = r_addr;
                                w_hdr_cmd_nxt  = r_cmd;
                                w_hdr_size_nxt = r_size;
                                w_hdr_num_nxt  = in_data;
                                w_pkt_ok_nxt   = 1'b1;
                            end
                            w_state_nxt = S_HEAD1;
                        end
                        default: begin
                            w_state_nxt = S_IDLE;
                        end
                    endcase
                end
            end
        endcase
    end

    // Parser state, pointers and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_crc        <= '0;
            r_timer      <= '0;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_size       <= '0;
            r_cmd        <= '0;
            r_skip       <= 1'b0;
            r_bad        <= 1'b0;
            r_pkt_start  <= 1'b0;
            r_pkt_ok     <= 1'b0;
            r_pkt_err    <= 1'b0;
            r_pkt_skip   <= 1'b0;
            r_err_code   <= '0;
            r_hdr_addr   <= '0;
            r_hdr_cmd    <= '0;
            r_hdr_size   <= '0;
            r_hdr_num    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_nxt;
            r_commit_ptr <= w_commit_nxt;
            r_crc        <= w_crc_nxt;
            r_timer      <= w_timer_nxt;
            r_cnt        <= w_cnt_nxt;
            r_addr       <= w_addr_nxt;
            r_size       <= w_size_nxt;
            r_cmd        <= w_cmd_nxt;
            r_skip       <= w_skip_nxt;
            r_bad        <= w_bad_nxt;
            r_pkt_start  <= w_pkt_start_nxt;
            r_pkt_ok     <= w_pkt_ok_nxt;
            r_pkt_err    <= w_pkt_err_nxt;
            r_pkt_skip   <= w_pkt_skip_nxt;
            r_err_code   <= w_err_code_nxt;
            r_hdr_addr   <= w_hdr_addr_nxt;
            r_hdr_cmd    <= w_hdr_cmd_nxt;
            r_hdr_size   <= w_hdr_size_nxt;
            r_hdr_num    <= w_hdr_num_nxt;
        end
    end

    // Read pointer advances on every accepted output word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Speculative payload write; contents are only exposed once committed.
    always_ff @(posedge clk) begin
        if (w_wr_en && !rst) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {w_wr_last, in_data};
        end
    end

    assign out_valid = w_out_valid;
    assign out_data  = w_out_valid ? w_rd_word[DATA_W-1:0] : '0;
    assign out_last  = w_out_valid ? w_rd_word[DATA_W] : 1'b0;
    assign pkt_start = r_pkt_start;
    assign pkt_ok    = r_pkt_ok;
    assign pkt_err   = r_pkt_err;
    assign pkt_skip  = r_pkt_skip;
    assign err_code  = r_err_code;
    assign hdr_addr  = r_hdr_addr;
    assign hdr_cmd   = r_hdr_cmd;
    assign hdr_size  = r_hdr_size;
    assign hdr_num   = r_hdr_num;
    assign buf_level = w_level;

endmodule

// File: tb/tb_sp_unpacker_buffered.sv
// Directed bench for sp_unpacker_buffered: framed packets in, status pulses and payload checked.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: out_ready held low to accumulate payload, then released to drain.
module tb_sp_unpacker_buffered;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_frame;
    logic        in_valid;
    logic [15:0] in_data;
    logic [15:0] own_addr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        pkt_start;
    logic        pkt_ok;
    logic        pkt_err;
    logic        pkt_skip;
    logic [2:0]  err_code;
    logic [15:0] hdr_addr;
    logic [7:0]  hdr_cmd;
    logic [7:0]  hdr_size;
    logic [15:0] hdr_num;
    logic [8:0]  buf_level;

    sp_unpacker_buffered #(
        .DATA_W(16), .BUF_DEPTH(256), .MAX_WORDS(255), .NUM_CMDS(8), .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk), .rst(rst), .in_frame(in_frame), .in_valid(in_valid), .in_data(in_data),
        .own_addr(own_addr), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .pkt_start(pkt_start), .pkt_ok(pkt_ok), .pkt_err(pkt_err),
        .pkt_skip(pkt_skip), .err_code(err_code), .hdr_addr(hdr_addr), .hdr_cmd(hdr_cmd),
        .hdr_size(hdr_size), .hdr_num(hdr_num), .buf_level(buf_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int n_start, n_ok, n_err, n_skip, n_valid, max_lvl;
    int excl_viol = 0;
    logic [2:0]  last_err;
    logic [16:0] got[$];
    logic [15:0] pay[$];

    // Negedge monitor: counts status pulses and collects popped words.
    always @(negedge clk) begin
        if (pkt_start) n_start++;
        if (pkt_ok)    n_ok++;
        if (pkt_skip)  n_skip++;
        if (pkt_err) begin
            n_err++;
            last_err = err_code;
        end
        if (pkt_ok && pkt_err) excl_viol++;
        if (out_valid) n_valid++;
        if (int'(buf_level) > max_lvl) max_lvl = int'(buf_level);
        if (out_valid && out_ready) got.push_back({out_last, out_data});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        n_start = 0; n_ok = 0; n_err = 0; n_skip = 0; n_valid = 0; max_lvl = 0;
        last_err = 3'd0;
        got.delete();
    endtask

    task automatic send_word(input logic [15:0] w);
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic frame_on();
        in_frame = 1'b1;
        tick(2);
    endtask

    task automatic frame_off();
        in_frame = 1'b0;
        tick(3);
    endtask

    // Sends a whole packet using the words in pay; adj perturbs the checksum.
    task automatic send_pkt(input logic [15:0] addr, input logic [7:0] size, input logic [7:0] cmd,
                            input logic [15:0] adj, input logic [15:0] num);
        logic [15:0] h2;
        logic [15:0] crc;
        h2  = {size, cmd};
        crc = addr + h2;
        send_word(addr);
        send_word(h2);
        for (int i = 0; i < pay.size(); i++) begin
            crc = crc + pay[i];
            send_word(pay[i]);
        end
        send_word(crc + adj);
        send_word(num);
    endtask

    initial begin
        int cnt;
        int bad;
        rst = 1'b1; in_frame = 1'b0; in_valid = 1'b0; in_data = '0;
        own_addr = 16'h0005; out_ready = 1'b0;
        tick(3);
        clr_mon();
        tick(1);

        // Reset state.
        chk("rst_out_valid", out_valid, 0);
        chk("rst_buf_level", buf_level, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_pulses", {pkt_start, pkt_ok, pkt_err, pkt_skip}, 0);
        chk("rst_hdr", {hdr_addr, hdr_cmd, hdr_size}, 0);
        chk("rst_hdr_num", hdr_num, 0);
        chk("rst_out_data", {out_last, out_data}, 0);
        rst = 1'b0;
        tick(2);

        // Good 3-word packet: 0005+0301+1111+2222+3333 = 696C.
        clr_mon();
        frame_on();
        send_word(16'h0005); send_word(16'h0301);
        send_word(16'h1111); send_word(16'h2222); send_word(16'h3333);
        send_word(16'h696C); send_word(16'h0007);
        tick(2);
        chk("t1_start", n_start, 1);
        chk("t1_ok", n_ok, 1);
        chk("t1_err", n_err, 0);
        chk("t1_hdr_size", hdr_size, 3);
        chk("t1_hdr_cmd", hdr_cmd, 1);
        chk("t1_hdr_num", hdr_num, 16'h0007);
        chk("t1_hdr_addr", hdr_addr, 16'h0005);
        chk("t1_level", buf_level, 3);
        chk("t1_head_word", {out_valid, out_last, out_data}, {2'b10, 16'h1111});
        frame_off();
        out_ready = 1'b1;
        tick(6);
        chk("t1_got_n", got.size(), 3);
        if (got.size() == 3) begin
            chk("t1_w0", got[0], {1'b0, 16'h1111});
            chk("t1_w1", got[1], {1'b0, 16'h2222});
            chk("t1_w2", got[2], {1'b1, 16'h3333});
        end
        chk("t1_level_end", buf_level, 0);

        // Same packet with a wrong checksum.
        clr_mon();
        frame_on();
        send_word(16'h0005); send_word(16'h0301);
        send_word(16'h1111); send_word(16'h2222); send_word(16'h3333);
        send_word(16'h696D); send_word(16'h0008);
        tick(2);
        chk("t2_err", n_err, 1);
        chk("t2_code", last_err, 1);
        chk("t2_ok", n_ok, 0);
        chk("t2_valid", n_valid, 0);
        chk("t2_level", buf_level, 0);
        chk("t2_hdr_num_kept", hdr_num, 16'h0007);
        frame_off();

        // Foreign address is skipped, then a broadcast size-0 packet.
        clr_mon();
        frame_on();
        pay = '{16'hAAAA, 16'hBBBB};
        send_pkt(16'h0009, 8'd2, 8'd1, 16'h0000, 16'h0011);
        tick(2);
        chk("t3_skip", n_skip, 1);
        chk("t3_start", n_start, 0);
        chk("t3_ok_err", {n_ok[7:0], n_err[7:0]}, 0);
        chk("t3_max_lvl", max_lvl, 0);
        clr_mon();
        pay.delete();
        send_pkt(16'hFFFF, 8'd0, 8'd2, 16'h0000, 16'h0042);
        tick(2);
        chk("t3b_ok", n_ok, 1);
        chk("t3b_start", n_start, 1);
        chk("t3b_hdr", {hdr_addr, hdr_cmd, hdr_size, hdr_num}, {16'hFFFF, 8'd2, 8'd0, 16'h0042});
        chk("t3b_valid", n_valid, 0);
        frame_off();

        // Two back-to-back packets held by backpressure.
        clr_mon();
        out_ready = 1'b0;
        frame_on();
        pay = '{16'h00A1, 16'h00A2};
        send_pkt(16'h0005, 8'd2, 8'd3, 16'h0000, 16'h0001);
        pay = '{16'h00B1, 16'h00B2};
        send_pkt(16'h0005, 8'd2, 8'd4, 16'h0000, 16'h0002);
        tick(2);
        chk("t4_level", buf_level, 4);
        chk("t4_ok", n_ok, 2);
        frame_off();
        out_ready = 1'b1;
        tick(8);
        chk("t4_got_n", got.size(), 4);
        if (got.size() == 4) begin
            chk("t4_w0", got[0], {1'b0, 16'h00A1});
            chk("t4_w1", got[1], {1'b1, 16'h00A2});
            chk("t4_w2", got[2], {1'b0, 16'h00B1});
            chk("t4_w3", got[3], {1'b1, 16'h00B2});
        end

        // Fill to 255 words, then a 2-word packet finds only one free slot.
        clr_mon();
        out_ready = 1'b0;
        frame_on();
        pay.delete();
        for (int i = 0; i < 255; i++) pay.push_back(16'(i * 3 + 7));
        send_pkt(16'h0005, 8'd255, 8'd0, 16'h0000, 16'h0009);
        tick(2);
        chk("t4f_level", buf_level, 255);
        chk("t4f_ok", n_ok, 1);
        pay = '{16'h00C1, 16'h00C2};
        send_pkt(16'h0005, 8'd2, 8'd0, 16'h0000, 16'h0009);
        tick(2);
        chk("t4n_err", n_err, 1);
        chk("t4n_code", last_err, 3);
        chk("t4n_ok", n_ok, 1);
        chk("t4n_level", buf_level, 255);
        frame_off();
        out_ready = 1'b1;
        tick(270);
        chk("t4d_got_n", got.size(), 255);
        bad = 0;
        for (int i = 0; i < got.size(); i++) begin
            if (got[i] !== {(i == 254), 16'(i * 3 + 7)}) bad++;
        end
        chk("t4d_words_bad", bad, 0);
        chk("t4d_level", buf_level, 0);

        // Unknown command: packet and rest of frame ignored.
        clr_mon();
        frame_on();
        pay = '{16'h00D1, 16'h00D2};
        send_pkt(16'h0005, 8'd2, 8'd9, 16'h0000, 16'h0003);
        pay = '{16'h00E1};
        send_pkt(16'h0005, 8'd1, 8'd0, 16'h0000, 16'h0004);
        tick(2);
        chk("t5_err", n_err, 1);
        chk("t5_code", last_err, 2);
        chk("t5_ok_start", {n_ok[7:0], n_start[7:0]}, 0);
        chk("t5_max_lvl", max_lvl, 0);
        frame_off();

        // Frame drops after the second data word.
        clr_mon();
        frame_on();
        send_word(16'h0005); send_word(16'h0301);
        send_word(16'h1111); send_word(16'h2222);
        tick(1);
        chk("t6_spec_level", buf_level, 2);
        in_frame = 1'b0;
        tick(3);
        chk("t6_err", n_err, 1);
        chk("t6_code", last_err, 6);
        chk("t6_level", buf_level, 0);
        chk("t6_valid", n_valid, 0);

        // Stall inside DATA until the inactivity timer expires.
        clr_mon();
        frame_on();
        send_word(16'h0005); send_word(16'h0301); send_word(16'h1111);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!pkt_err && cnt < 1200);
        chk("t7_timeout_cycles", cnt, 1025);
        chk("t7_code", err_code, 5);
        @(posedge clk);
        #1;
        tick(1);
        chk("t7_level", buf_level, 0);
        pay = '{16'h00F1, 16'h00F2, 16'h00F3};
        send_pkt(16'h0005, 8'd3, 8'd5, 16'h0000, 16'h0006);
        tick(6);
        chk("t7_ok", n_ok, 1);
        chk("t7_err", n_err, 1);
        chk("t7_got_n", got.size(), 3);
        if (got.size() == 3) chk("t7_w2", got[2], {1'b1, 16'h00F3});
        frame_off();

        // Reset with committed data discards it.
        clr_mon();
        out_ready = 1'b0;
        frame_on();
        pay = '{16'h0101, 16'h0202};
        send_pkt(16'h0005, 8'd2, 8'd1, 16'h0000, 16'h0010);
        tick(2);
        chk("t8_level_pre", buf_level, 2);
        rst = 1'b1;
        tick(2);
        chk("t8_level_rst", buf_level, 0);
        chk("t8_valid_rst", out_valid, 0);
        chk("t8_hdr_rst", hdr_num, 0);
        rst = 1'b0;
        in_frame = 1'b0;
        tick(2);

        chk("ok_err_exclusive", excl_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
